mips_hilo_ctrl: RTL and testbench



---
 rtl/mips_hilo_ctrl.sv | 131 +++++++++++++
 tb/tb_mips_hilo_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mips_hilo_ctrl.sv
// rtl/mips_hilo_ctrl.sv - HI/LO register unit and issue controller for a pipelined multiplier
module mips_hilo_ctrl #(
    parameter int DATA_W   = 32,
    parameter int MULT_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op_code,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              stall,
    output logic [DATA_W-1:0] rd_data,
    output logic              mult_start,
    output logic [DATA_W-1:0] mult_src_a,
    output logic [DATA_W-1:0] mult_src_b,
    input  logic              mult_done,
    input  logic [DATA_W-1:0] mult_lower,
    input  logic [DATA_W-1:0] mult_higher,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd3;
    localparam logic [2:0] OP_MTLO  = 3'd4;
    localparam logic [2:0] OP_MFHI  = 3'd5;
    localparam logic [2:0] OP_MFLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    localparam int P_W  = 2 * DATA_W;
    localparam int WD_W = $clog2(MULT_LAT + 2);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MULT_LAT);

    logic [0:0]      state;
    logic            neg;
    logic [WD_W-1:0] wd;
    logic            op_real;
    logic            accept;
    logic [P_W-1:0]  product;
    logic [P_W-1:0]  product_signed;

    // Two's-complement magnitude; the most negative value maps onto itself,
    // which is the correct unsigned magnitude for the multiplier.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
    endfunction

    assign op_real = op_valid && (op_code != OP_NOP) && (op_code != OP_RSVD);
    assign accept  = op_real && (state == S_IDLE);
    assign stall   = op_real && (state == S_BUSY);

    assign product        = {mult_higher, mult_lower};
    assign product_signed = neg ? (~product + {{(P_W-1){1'b0}}, 1'b1}) : product;

    always_comb begin
        rd_data = '0;
        if (accept && op_code == OP_MFHI) begin
            rd_data = hi;
        end else if (accept && op_code == OP_MFLO) begin
            rd_data = lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            hi         <= '0;
            lo         <= '0;
            mult_start <= 1'b0;
            mult_src_a <= '0;
            mult_src_b <= '0;
            err        <= 1'b0;
            neg        <= 1'b0;
            wd         <= '0;
        end else begin
            mult_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mult_done) begin
                        err <= 1'b1;
                    end
                    if (accept) begin
                        case (op_code)
                            OP_MULTU: begin
                                mult_start <= 1'b1;
                                mult_src_a <= src_a;
                                mult_src_b <= src_b;
                                neg        <= 1'b0;
                                wd         <= '0;
                                state      <= S_BUSY;
                            end
                            OP_MULT: begin
                                mult_start <= 1'b1;
                                mult_src_a <= magnitude(src_a);
                                mult_src_b <= magnitude(src_b);
                                neg        <= src_a[DATA_W-1] ^ src_b[DATA_W-1];
                                wd         <= '0;
                                state      <= S_BUSY;
                            end
                            OP_MTHI: hi <= src_a;
                            OP_MTLO: lo <= src_a;
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    // Held ops stay stalled through the done cycle and replay against the new HI/LO.
                    if (mult_done) begin
                        {hi, lo} <= product_signed;
                        state    <= S_IDLE;
                    end else if (wd == WD_LAST) begin
                        err   <= 1'b1;
                        wd    <= wd + 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_hilo_ctrl.sv
// tb/tb_mips_hilo_ctrl.sv - table-driven self-checking bench for mips_hilo_ctrl
module tb_mips_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] src_a, src_b;
    logic        stall;
    logic [31:0] rd_data;
    logic        mult_start;
    logic [31:0] mult_src_a, mult_src_b;
    logic        mult_done;
    logic [31:0] mult_lower, mult_higher;
    logic [31:0] hi, lo;
    logic        err;

    int total = 0;
    int bad   = 0;

    mips_hilo_ctrl #(.DATA_W(32), .MULT_LAT(4)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
        .src_a(src_a), .src_b(src_b), .stall(stall), .rd_data(rd_data),
        .mult_start(mult_start), .mult_src_a(mult_src_a), .mult_src_b(mult_src_b),
        .mult_done(mult_done), .mult_lower(mult_lower), .mult_higher(mult_higher),
        .hi(hi), .lo(lo), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ov;
        logic [2:0]  oc;
        logic [31:0] a, b;
        logic        dn;
        logic [31:0] plo, phi;
        logic        st;
        logic [31:0] rd;
        logic        ms;
        logic [31:0] msa, msb, hv, lv;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ov, input logic [2:0] oc, input logic [31:0] a, input logic [31:0] b,
                       input logic dn, input logic [31:0] plo, input logic [31:0] phi,
                       input logic st, input logic [31:0] rd, input logic ms,
                       input logic [31:0] msa, input logic [31:0] msb,
                       input logic [31:0] hv, input logic [31:0] lv, input logic er);
        vec_t v;
        v.ov = ov; v.oc = oc; v.a = a; v.b = b; v.dn = dn; v.plo = plo; v.phi = phi;
        v.st = st; v.rd = rd; v.ms = ms; v.msa = msa; v.msb = msb; v.hv = hv; v.lv = lv; v.er = er;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ov, input logic [2:0] oc, input logic [31:0] a, input logic [31:0] b,
                         input logic dn, input logic [31:0] plo, input logic [31:0] phi);
        op_valid = ov; op_code = oc; src_a = a; src_b = b;
        mult_done = dn; mult_lower = plo; mult_higher = phi;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // c0..c7: MULTU FFFFFFFF*FFFFFFFF
        add(0,0,0,0, 0,0,0,                         0,0,0, 0,0, 0,0,0);
        add(1,2,32'hFFFFFFFF,32'hFFFFFFFF, 0,0,0,   0,0,0, 0,0, 0,0,0);
        add(0,0,0,0, 0,0,0,                         0,0,1, 32'hFFFFFFFF,32'hFFFFFFFF, 0,0,0);
        for (int i = 0; i < 3; i++)
            add(0,0,0,0, 0,0,0,                     0,0,0, 32'hFFFFFFFF,32'hFFFFFFFF, 0,0,0);
        add(0,0,0,0, 1,32'h00000001,32'hFFFFFFFE,   0,0,0, 32'hFFFFFFFF,32'hFFFFFFFF, 0,0,0);
        add(0,0,0,0, 0,0,0,                         0,0,0, 32'hFFFFFFFF,32'hFFFFFFFF, 32'hFFFFFFFE,1,0);
        // c8..c14: MULT -3*5 with MFLO held from T+2
        add(1,1,32'hFFFFFFFD,5, 0,0,0,              0,0,0, 32'hFFFFFFFF,32'hFFFFFFFF, 32'hFFFFFFFE,1,0);
        add(0,0,0,0, 0,0,0,                         0,0,1, 3,5, 32'hFFFFFFFE,1,0);
        for (int i = 0; i < 3; i++)
            add(1,6,0,0, 0,0,0,                     1,0,0, 3,5, 32'hFFFFFFFE,1,0);
        add(1,6,0,0, 1,32'h0000000F,0,              1,0,0, 3,5, 32'hFFFFFFFE,1,0);
        add(1,6,0,0, 0,0,0,                         0,32'hFFFFFFF1,0, 3,5, 32'hFFFFFFFF,32'hFFFFFFF1,0);
        // c15..c21: MULT 0x80000000*0x80000000
        add(1,1,32'h80000000,32'h80000000, 0,0,0,   0,0,0, 3,5, 32'hFFFFFFFF,32'hFFFFFFF1,0);
        add(0,0,0,0, 0,0,0,                         0,0,1, 32'h80000000,32'h80000000, 32'hFFFFFFFF,32'hFFFFFFF1,0);
        for (int i = 0; i < 3; i++)
            add(0,0,0,0, 0,0,0,                     0,0,0, 32'h80000000,32'h80000000, 32'hFFFFFFFF,32'hFFFFFFF1,0);
        add(0,0,0,0, 1,0,32'h40000000,              0,0,0, 32'h80000000,32'h80000000, 32'hFFFFFFFF,32'hFFFFFFF1,0);
        add(0,0,0,0, 0,0,0,                         0,0,0, 32'h80000000,32'h80000000, 32'h40000000,0,0);
        // c22..c30: MTHI/MFHI back to back, then MULTU 7*6 with MFLO held
        add(1,3,32'h1234,0, 0,0,0,                  0,0,0, 32'h80000000,32'h80000000, 32'h40000000,0,0);
        add(1,5,0,0, 0,0,0,                         0,32'h1234,0, 32'h80000000,32'h80000000, 32'h1234,0,0);
        add(1,2,7,6, 0,0,0,                         0,0,0, 32'h80000000,32'h80000000, 32'h1234,0,0);
        add(1,6,0,0, 0,0,0,                         1,0,1, 7,6, 32'h1234,0,0);
        for (int i = 0; i < 3; i++)
            add(1,6,0,0, 0,0,0,                     1,0,0, 7,6, 32'h1234,0,0);
        add(1,6,0,0, 1,32'h2A,0,                    1,0,0, 7,6, 32'h1234,0,0);
        add(1,6,0,0, 0,0,0,                         0,32'h2A,0, 7,6, 0,32'h2A,0);
        // c31..c39: MTLO held across BUSY, colliding with done; lands afterwards
        add(1,2,3,4, 0,0,0,                         0,0,0, 7,6, 0,32'h2A,0);
        add(1,4,32'hBEEF,0, 0,0,0,                  1,0,1, 3,4, 0,32'h2A,0);
        for (int i = 0; i < 3; i++)
            add(1,4,32'hBEEF,0, 0,0,0,              1,0,0, 3,4, 0,32'h2A,0);
        add(1,4,32'hBEEF,0, 1,32'hC,0,              1,0,0, 3,4, 0,32'h2A,0);
        add(1,4,32'hBEEF,0, 0,0,0,                  0,0,0, 3,4, 0,32'hC,0);
        add(1,6,0,0, 0,0,0,                         0,32'hBEEF,0, 3,4, 0,32'hBEEF,0);
        add(1,7,0,0, 0,0,0,                         0,0,0, 3,4, 0,32'hBEEF,0);

        rst = 1'b1;
        drive(0,0,0,0, 0,0,0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ov, vecs[i].oc, vecs[i].a, vecs[i].b, vecs[i].dn, vecs[i].plo, vecs[i].phi);
            #1;
            chk($sformatf("row%0d stall", i),   32'(stall),      32'(vecs[i].st));
            chk($sformatf("row%0d rd_data", i), rd_data,         vecs[i].rd);
            chk($sformatf("row%0d start", i),   32'(mult_start), 32'(vecs[i].ms));
            chk($sformatf("row%0d src_a", i),   mult_src_a,      vecs[i].msa);
            chk($sformatf("row%0d src_b", i),   mult_src_b,      vecs[i].msb);
            chk($sformatf("row%0d hi", i),      hi,              vecs[i].hv);
            chk($sformatf("row%0d lo", i),      lo,              vecs[i].lv);
            chk($sformatf("row%0d err", i),     32'(err),        32'(vecs[i].er));
            tick();
        end

        // Watchdog: MULT 2*3 with no done ever returned
        drive(1,1,2,3, 0,0,0);
        tick();
        drive(0,0,0,0, 0,0,0);
        #1 chk("wd start", 32'(mult_start), 32'd1);
        repeat (4) tick();
        #1 chk("wd err before limit", 32'(err), 32'd0);
        tick();
        drive(1,6,0,0, 0,0,0);
        #1;
        chk("wd err", 32'(err), 32'd1);
        chk("wd idle stall", 32'(stall), 32'd0);
        chk("wd idle rd", rd_data, 32'hBEEF);
        chk("wd hi kept", hi, 32'd0);
        chk("wd lo kept", lo, 32'hBEEF);
        tick();

        // Reset in the middle of a MULT
        drive(1,3,32'h5555,0, 0,0,0);
        tick();
        drive(1,1,5,5, 0,0,0);
        tick();
        drive(0,0,0,0, 0,0,0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1,6,0,0, 0,0,0);
        #1;
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst rd", rd_data, 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst start", 32'(mult_start), 32'd0);
        tick();

        // Spurious done while IDLE
        drive(0,0,0,0, 1,32'hFFFF,32'hFFFF);
        #1 chk("spur err before", 32'(err), 32'd0);
        tick();
        drive(0,0,0,0, 0,0,0);
        #1;
        chk("spur err", 32'(err), 32'd1);
        chk("spur hi", hi, 32'd0);
        chk("spur lo", lo, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
